deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Downstream stage of the byte serializer. Takes the 1-bit stream (`in`, LSB first) and its enable (`in_en`).
- Rebuilds 8-bit bytes from each enabled run of 8 bits and buffers them in a small FIFO.
- Presents bytes to the consumer over a valid/ready handshake.
- Flags partial bytes (enable drops early) and bytes lost to a full FIFO.

Parameters:
- DEPTH, 4, number of FIFO byte entries (power of two, at least 2).
- AW, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial data bit; sampled only when in_en=1.
- in_en  input  1  serial bit qualifier; stays high for the 8 cycles of one byte.
- out  output  8  byte at the FIFO head; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head byte on a cycle where out_valid=1 and out_ready=1.
- frag_err  output  1  one-cycle pulse: partial byte discarded.
- ovf  output  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- count  output  AW+1  current number of FIFO entries.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high, as already decided.
  - Reset takes priority over all other activity in the same cycle.
- Reset values:
  - Shift register = 0, bit counter = 0, state = IDLE.
  - FIFO read and write pointers = 0, count = 0.
  - out_valid = 0, frag_err = 0, ovf = 0, out = 0.
  - Reset during a byte discards that partial byte and raises no frag_err.
- Receive FSM, two states:
  - IDLE, in_en=1: sample `in` into bit 0 of the shift register, set bit counter = 1, go to RECV.
  - RECV, in_en=1, bit counter k < 7: write `in` into bit k, then increment the counter.
  - RECV, in_en=1, k = 7: write `in` into bit 7 and attempt a FIFO push of the completed byte. Set the counter to 0 and go to IDLE.
  - RECV, in_en=0: discard the partial byte, set the counter to 0, go to IDLE. frag_err=1 for the next cycle only.
- Back-to-back bytes: in_en held high for 16 cycles gives two bytes. The cycle after a completed byte is handled from IDLE, so no dead cycle is needed between bytes.
- Bit order: first bit received becomes out[0]; the eighth becomes out[7].
- FIFO push and pop:
  - A push happens at the edge that samples bit 7.
  - The byte is visible on `out`, with out_valid=1, in the cycle after that edge if the FIFO was empty.
  - Minimum latency from the bit-7 sample edge to out_valid is 1 cycle.
  - A pop occurs when out_valid=1 and out_ready=1; the read pointer advances at that edge.
  - out_ready while out_valid=0 has no effect.
- FIFO outputs: out = mem[rd_ptr], driven from registers. out_valid = (count != 0).
- Full FIFO:
  - A push when count = DEPTH and no pop in the same cycle drops the byte. ovf=1 for the next cycle; pointers and count are unchanged.
  - Push and pop in the same cycle while full: the push is accepted and count stays at DEPTH.
- Empty FIFO: push and pop cannot coincide, because a pop requires out_valid. Count increments.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- frag_err and ovf are registered single-cycle pulses. They can both assert in the same cycle only from independent events; none are defined.
- `in` is ignored whenever in_en=0.

Test Plan:
- Single byte: in_en=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 (LSB first), out_ready=1.
  - out_valid=1 for exactly one cycle, 1 cycle after the 8th sample, with out=8'hA5.
  - count goes 0 -> 1 -> 0.
- Back-to-back: 16 enabled cycles carrying 8'h3C then 8'hC3, out_ready=0.
  - count=2, out=8'h3C.
  - Assert out_ready: 8'h3C is popped, then 8'hC3, then out_valid=0.
- Fragment: in_en=1 for 5 cycles, then 0.
  - frag_err pulses once, the cycle after in_en falls.
  - count stays 0.
  - A following full byte 8'h0F is received intact.
- Overflow: out_ready=0, send 5 bytes 8'h01..8'h05 with DEPTH=4.
  - count=4, and ovf pulses once after the 5th byte.
  - Drain gives 01,02,03,04.
- Full with simultaneous pop: FIFO full (01..04), out_ready=1 held across the completion edge of byte 8'h05.
  - No ovf, count stays 4.
  - Drain gives 02,03,04,05.
- Reset mid-operation: assert reset after 3 bits of a byte with 2 bytes buffered.
  - Next cycle: count=0, out_valid=0, frag_err=0, ovf=0.
  - The next 8-bit run 8'h5A is received correctly.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-byte deserializer with a small byte FIFO and valid/ready output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no byte in progress; next enabled bit starts a new byte
// RECV  | collecting bits 1..7 of a byte; bit_cnt is the next bit index
module deserializer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in,
    input  logic          in_en,
    output logic [7:0]    out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          frag_err,
    output logic          ovf,
    output logic [AW:0]   count
);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_RECV   = 1'b1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [0:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          byte_done;
    logic          frag_det;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [7:0]    assembled;

    // Byte completion, fragment detection and FIFO push/pop decisions.
    always_comb begin
        byte_done = 1'b0;
        frag_det  = 1'b0;
        assembled = {in, shreg[6:0]};
        if (state == S_RECV) begin
            byte_done = in_en && (bit_cnt == 3'd7);
            frag_det  = !in_en;
        end
        pop = out_valid && out_ready;
        full = (count == FULL_CNT);
        // When full, a same-cycle pop frees the slot the push lands in.
        push_ok = byte_done && (!full || pop);
        drop    = byte_done && full && !pop;
    end

    // Receive FSM: shift enabled bits in LSB first and flag truncated bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            frag_err <= 1'b0;
        end else begin
            frag_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_en) begin
                        shreg[0] <= in;
                        bit_cnt  <= 3'd1;
                        state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (in_en) begin
                        shreg[bit_cnt] <= in;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        bit_cnt  <= 3'd0;
                        state    <= S_IDLE;
                        frag_err <= 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= 3'd0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Byte FIFO: storage, wrapping pointers, occupancy and overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            ovf <= drop;
            if (push_ok) begin
                mem[wr_ptr] <= assembled;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head of FIFO straight from the storage registers.
    always_comb begin
        out       = mem[rd_ptr];
        out_valid = (count != '0);
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: a vector table plus multi-cycle sequences.
module tb_deserializer;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_en;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       frag_err;
    logic       ovf;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    deserializer #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_bit),
        .in_en     (in_en),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frag_err  (frag_err),
        .ovf       (ovf),
        .count     (count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       bit_in;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_out;
        logic [2:0] exp_cnt;
        logic       exp_frag;
        logic       exp_ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [8:0] actual, input logic [8:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ready_last);
        for (int i = 0; i < 8; i++) begin
            in_en  = 1'b1;
            in_bit = b[i];
            if (i == 7 && ready_last) out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic idle();
        in_en  = 1'b0;
        in_bit = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] x0f;
        a5  = 8'hA5;
        x0f = 8'h0F;

        reset     = 1'b1;
        in_bit    = 1'b0;
        in_en     = 1'b0;
        out_ready = 1'b0;

        // Reset row, then single byte A5 with out_ready held high.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            vecs[1+i] = '{1'b0, 1'b1, a5[i], 1'b1, (i == 7), 8'hA5, 3'((i == 7)), 1'b0, 1'b0};
        end
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        // Five-bit fragment, then a full 0F byte held in the FIFO.
        for (int i = 0; i < 5; i++) begin
            vecs[11+i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        end
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            vecs[18+i] = '{1'b0, 1'b1, x0f[i], 1'b0, (i == 7), 8'h0F, 3'((i == 7)), 1'b0, 1'b0};
        end
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        for (int v = 0; v < NV; v++) begin
            reset     = vecs[v].rst;
            in_en     = vecs[v].en;
            in_bit    = vecs[v].bit_in;
            out_ready = vecs[v].rdy;
            tick();
            check($sformatf("vec%0d out_valid", v), 9'(out_valid), 9'(vecs[v].exp_valid));
            check($sformatf("vec%0d count", v), 9'(count), 9'(vecs[v].exp_cnt));
            check($sformatf("vec%0d frag_err", v), 9'(frag_err), 9'(vecs[v].exp_frag));
            check($sformatf("vec%0d ovf", v), 9'(ovf), 9'(vecs[v].exp_ovf));
            if (vecs[v].exp_valid) check($sformatf("vec%0d out", v), 9'(out), 9'(vecs[v].exp_out));
            if (v == 0) check("reset out", 9'(out), 9'h000);
        end
        reset     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Back-to-back 3C, C3 with no gap.
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        idle();
        check("b2b count", 9'(count), 9'd2);
        check("b2b head", 9'(out), 9'h3C);
        out_ready = 1'b1;
        tick();
        check("b2b second", 9'(out), 9'hC3);
        check("b2b count1", 9'(count), 9'd1);
        tick();
        check("b2b empty", 9'(out_valid), 9'd0);
        out_ready = 1'b0;

        // Overflow: five bytes into a four-entry FIFO.
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
        check("ovf count full", 9'(count), 9'd4);
        check("ovf quiet before", 9'(ovf), 9'd0);
        send_byte(8'h05, 1'b0);
        check("ovf pulse", 9'(ovf), 9'd1);
        check("ovf count held", 9'(count), 9'd4);
        idle();
        check("ovf pulse end", 9'(ovf), 9'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf drain%0d", k), 9'(out), 9'(k));
            tick();
        end
        out_ready = 1'b0;
        check("ovf drained", 9'(count), 9'd0);

        // Full FIFO with a pop on the completion edge of the fifth byte.
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
        send_byte(8'h05, 1'b1);
        check("fullpop ovf", 9'(ovf), 9'd0);
        check("fullpop count", 9'(count), 9'd4);
        idle();
        check("fullpop ovf later", 9'(ovf), 9'd0);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("fullpop drain%0d", k), 9'(out), 9'(k));
            tick();
        end
        out_ready = 1'b0;
        check("fullpop drained", 9'(out_valid), 9'd0);

        // Reset three bits into a byte with two bytes buffered.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_en  = 1'b1;
            in_bit = 1'b1;
            tick();
        end
        check("pre-reset count", 9'(count), 9'd2);
        do_reset();
        check("rst count", 9'(count), 9'd0);
        check("rst valid", 9'(out_valid), 9'd0);
        check("rst frag", 9'(frag_err), 9'd0);
        check("rst ovf", 9'(ovf), 9'd0);
        check("rst out", 9'(out), 9'd0);
        idle();
        check("rst frag later", 9'(frag_err), 9'd0);
        send_byte(8'h5A, 1'b0);
        check("post-rst valid", 9'(out_valid), 9'd1);
        check("post-rst out", 9'(out), 9'h5A);
        check("post-rst count", 9'(count), 9'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
